// File: rtl/grid_rr_scheduler.sv
// grid_rr_scheduler
//   A ROWS x COLS grid of requester cells feeding one shared output with a
//   round-robin grant. Each cell latches one payload and holds it pending until
//   the shared output transfers it. A request that arrives while its cell is
//   still pending is discarded and reported on drop.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous active-high reset
//   req        in   [N]     per-cell request strobe, bit k = i*COLS+j
//   req_data   in   [N*DW]  per-cell payload, slice k at [k*DW +: DW]
//   out_valid  out  shared output holds a granted payload
//   out_ready  in   consumer accepts the payload
//   out_data   out  [DW]    granted payload
//   out_idx    out  [IW]    flat index of the granted cell
//   drop       out  one-cycle pulse when any request was discarded
//   grant_cnt  out  [8]     completed transfers, wraps 255 -> 0
//
// Build option
//   GRID_RR_SCHEDULER_ASSERT_EN  when defined, compiles immediate assertions
//   on grant/pending consistency. Port behaviour is identical either way.

module grid_rr_scheduler #(
    parameter int ROWS = 2,
    parameter int COLS = 2,
    parameter int DW   = 8,
    localparam int N   = ROWS * COLS,
    localparam int IW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*DW-1:0] req_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic [IW-1:0]   out_idx,
    output logic            drop,
    output logic [7:0]      grant_cnt
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [N-1:0]    pend_vec;
    logic [DW-1:0]   cell_data [N];
    logic [N-1:0]    done;
    logic            complete;
    logic            sel_found;
    logic [IW-1:0]   sel_idx;

    assign complete = (state == GRANT) && out_ready;

    // One-hot release of the cell whose payload is leaving this cycle.
    always_comb begin
        done = '0;
        for (int k = 0; k < N; k++) begin
            done[k] = complete && (out_idx == IW'(k));
        end
    end

    // Per-cell storage. A completing cell may re-latch in the same cycle,
    // which keeps it pending without counting as a discard.
    for (genvar i = 0; i < ROWS; i++) begin : row
        for (genvar j = 0; j < COLS; j++) begin : col
            localparam int K = i * COLS + j;
            logic          pending;
            logic [DW-1:0] data;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pending <= 1'b0;
                    data    <= '0;
                end else if (req[K] && (!pending || done[K])) begin
                    pending <= 1'b1;
                    data    <= req_data[K*DW +: DW];
                end else if (done[K]) begin
                    pending <= 1'b0;
                end
            end

            assign pend_vec[K]  = pending;
            assign cell_data[K] = data;
        end
    end

    // Round-robin pick: first pending cell at or after ptr, wrapping.
    always_comb begin
        int k;
        k         = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int o = 0; o < N; o++) begin
            k = int'(ptr) + o;
            if (k >= N) begin
                k = k - N;
            end
            if (!sel_found && pend_vec[IW'(k)]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(k);
            end
        end
    end

    // Grant FSM with registered outputs. Leaving GRANT always passes through
    // IDLE for at least one cycle, so a new pick sees the updated ptr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            grant_cnt <= '0;
            drop      <= 1'b0;
        end else begin
            drop <= |(req & pend_vec & ~done);
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        out_idx   <= sel_idx;
                        out_data  <= cell_data[sel_idx];
                        out_valid <= 1'b1;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (out_ready) begin
                        if (out_idx == IW'(N - 1)) begin
                            ptr <= '0;
                        end else begin
                            ptr <= out_idx + 1'b1;
                        end
                        grant_cnt <= grant_cnt + 8'd1;
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef GRID_RR_SCHEDULER_ASSERT_EN
    // The granted cell must stay pending for the whole grant.
    for (genvar i = 0; i < ROWS; i++) begin : chk_row
        for (genvar j = 0; j < COLS; j++) begin : chk_col
            always @* begin
                if (!rst && out_valid && (out_idx == IW'(i * COLS + j))) begin
                    assert (row[i].col[j].pending)
                        else $error("granted cell %0d not pending", i * COLS + j);
                end
            end
        end
    end

    always @* begin
        if (!rst) begin
            assert ($onehot0(done))
                else $error("more than one cell released");
            assert (out_valid == (state == GRANT))
                else $error("out_valid disagrees with grant state");
            assert (int'(ptr) < N)
                else $error("ptr out of range");
        end
    end
`endif

endmodule

// File: tb/tb_grid_rr_scheduler.sv
// Directed bench for grid_rr_scheduler (2x2 grid, 8-bit payload).
// A vector table drives one clock edge per entry and compares the outputs
// registered by that edge; hand-written sequences cover stall, reset
// during a grant and the grant counter wrap.

module tb_grid_rr_scheduler;

    localparam int N  = 4;
    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req;
    logic [N*DW-1:0] req_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    out_idx;
    logic          drop;
    logic [7:0]    grant_cnt;

    int checks = 0;
    int errors = 0;

    grid_rr_scheduler #(.ROWS(2), .COLS(2), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .drop      (drop),
        .grant_cnt (grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic        rdy;
        logic        ev;
        logic [1:0]  ei;
        logic [7:0]  ed;
        logic        edrop;
        logic [7:0]  ecnt;
    } vec_t;

    vec_t vecs [22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // req, data, ready | valid, idx, data, drop, cnt
        vecs[0]  = '{4'b1000, 32'hA500_0000, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 8'd0};
        vecs[1]  = '{4'b0000, 32'h0000_0000, 1'b1, 1'b1, 2'd3, 8'hA5, 1'b0, 8'd0};
        vecs[2]  = '{4'b0000, 32'h0000_0000, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 8'd1};
        vecs[3]  = '{4'b1111, 32'h4433_2211, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 8'd1};
        vecs[4]  = '{4'b0000, 32'h0000_0000, 1'b1, 1'b1, 2'd0, 8'h11, 1'b0, 8'd1};
        vecs[5]  = '{4'b0000, 32'h0000_0000, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 8'd2};
        vecs[6]  = '{4'b0000, 32'h0000_0000, 1'b1, 1'b1, 2'd1, 8'h22, 1'b0, 8'd2};
        vecs[7]  = '{4'b0000, 32'h0000_0000, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 8'd3};
        vecs[8]  = '{4'b0000, 32'h0000_0000, 1'b1, 1'b1, 2'd2, 8'h33, 1'b0, 8'd3};
        vecs[9]  = '{4'b0000, 32'h0000_0000, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 8'd4};
        vecs[10] = '{4'b0000, 32'h0000_0000, 1'b1, 1'b1, 2'd3, 8'h44, 1'b0, 8'd4};
        vecs[11] = '{4'b0000, 32'h0000_0000, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 8'd5};
        vecs[12] = '{4'b0010, 32'h0000_5C00, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 8'd5};
        vecs[13] = '{4'b0010, 32'h0000_7700, 1'b1, 1'b1, 2'd1, 8'h5C, 1'b1, 8'd5};
        vecs[14] = '{4'b0000, 32'h0000_0000, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 8'd6};
        vecs[15] = '{4'b0011, 32'h0000_1B0A, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 8'd6};
        vecs[16] = '{4'b0000, 32'h0000_0000, 1'b1, 1'b1, 2'd0, 8'h0A, 1'b0, 8'd6};
        vecs[17] = '{4'b0001, 32'h0000_00C3, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 8'd7};
        vecs[18] = '{4'b0000, 32'h0000_0000, 1'b1, 1'b1, 2'd1, 8'h1B, 1'b0, 8'd7};
        vecs[19] = '{4'b0000, 32'h0000_0000, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 8'd8};
        vecs[20] = '{4'b0000, 32'h0000_0000, 1'b1, 1'b1, 2'd0, 8'hC3, 1'b0, 8'd8};
        vecs[21] = '{4'b0000, 32'h0000_0000, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 8'd9};

        rst       = 1'b1;
        req       = '0;
        req_data  = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_cnt",   {24'd0, grant_cnt}, 32'd0);
        check("rst_drop",  {31'd0, drop}, 32'd0);
        check("rst_idx",   {30'd0, out_idx}, 32'd0);
        check("rst_data",  {24'd0, out_data}, 32'd0);
        rst = 1'b0;

        // Table-driven main sequence
        for (int v = 0; v < 22; v++) begin
            req       = vecs[v].req;
            req_data  = vecs[v].data;
            out_ready = vecs[v].rdy;
            tick();
            check($sformatf("vec%0d_valid", v), {31'd0, out_valid}, {31'd0, vecs[v].ev});
            check($sformatf("vec%0d_drop", v),  {31'd0, drop}, {31'd0, vecs[v].edrop});
            check($sformatf("vec%0d_cnt", v),   {24'd0, grant_cnt}, {24'd0, vecs[v].ecnt});
            if (vecs[v].ev) begin
                check($sformatf("vec%0d_idx", v),  {30'd0, out_idx}, {30'd0, vecs[v].ei});
                check($sformatf("vec%0d_data", v), {24'd0, out_data}, {24'd0, vecs[v].ed});
            end
        end

        // Stall: out_ready low for 5 cycles while granted
        req       = 4'b0100;
        req_data  = 32'h005A_0000;
        out_ready = 1'b0;
        tick();
        req      = '0;
        req_data = '0;
        tick();
        for (int c = 0; c < 5; c++) begin
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_idx",   {30'd0, out_idx}, 32'd2);
            check("stall_data",  {24'd0, out_data}, 32'h5A);
            check("stall_cnt",   {24'd0, grant_cnt}, 32'd9);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("stall_done_valid", {31'd0, out_valid}, 32'd0);
        check("stall_done_cnt",   {24'd0, grant_cnt}, 32'd10);

        // Reset in the middle of a grant
        req       = 4'b0001;
        req_data  = 32'h0000_003C;
        out_ready = 1'b0;
        tick();
        req      = '0;
        req_data = '0;
        tick();
        check("mid_grant_valid", {31'd0, out_valid}, 32'd1);
        check("mid_grant_data",  {24'd0, out_data}, 32'h3C);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_cnt",   {24'd0, grant_cnt}, 32'd0);
        check("async_rst_data",  {24'd0, out_data}, 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("post_rst_no_grant", {31'd0, out_valid}, 32'd0);
            check("post_rst_cnt",      {24'd0, grant_cnt}, 32'd0);
        end

        // 256 completions wrap the counter
        for (int n = 1; n <= 256; n++) begin
            int waited;
            req      = 4'b0001;
            req_data = n;
            tick();
            req      = '0;
            req_data = '0;
            waited   = 0;
            while (!out_valid && waited < 4) begin
                tick();
                waited++;
            end
            check("wrap_grant", {31'd0, out_valid}, 32'd1);
            tick();
            if (n == 255) check("wrap_cnt_255", {24'd0, grant_cnt}, 32'd255);
            if (n == 256) check("wrap_cnt_0",   {24'd0, grant_cnt}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
